// File: rtl/alu_station_pkg.sv
// Shared ALU station types, tag constants and opcode map.
// Used by alu_core and alu_station (optional feature macro: ALU_CDB_BYPASS_EN).
package alu_station_pkg;

    localparam int unsigned TAG_BITS  = 4;
    localparam int unsigned WORD_BITS = 32;
    localparam int unsigned ADDR_BITS = 5;

    typedef logic [WORD_BITS-1:0] word_t;
    typedef logic [TAG_BITS-1:0]  regtag_t;
    typedef logic [3:0]           sinst_t;

    localparam regtag_t UNLOCKED   = 4'd0;
    localparam regtag_t ALU_MASTER = 4'd1;

    localparam sinst_t ALU_OP_ADD  = 4'd0;
    localparam sinst_t ALU_OP_SUB  = 4'd1;
    localparam sinst_t ALU_OP_SLL  = 4'd2;
    localparam sinst_t ALU_OP_SLT  = 4'd3;
    localparam sinst_t ALU_OP_SLTU = 4'd4;
    localparam sinst_t ALU_OP_XOR  = 4'd5;
    localparam sinst_t ALU_OP_SRL  = 4'd6;
    localparam sinst_t ALU_OP_SRA  = 4'd7;
    localparam sinst_t ALU_OP_OR   = 4'd8;
    localparam sinst_t ALU_OP_AND  = 4'd9;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU: op, x, y -> result. Undefined opcodes yield 0.
module alu_core
    import alu_station_pkg::*;
#(
    parameter int unsigned WORD_W = WORD_BITS
) (
    input  logic [3:0]        op,
    input  logic [WORD_W-1:0] x,
    input  logic [WORD_W-1:0] y,
    output logic [WORD_W-1:0] result
);

    logic [4:0] shamt;
    assign shamt = y[4:0];

    always_comb begin
        result = '0;
        case (op)
            ALU_OP_ADD:  result = x + y;
            ALU_OP_SUB:  result = x - y;
            ALU_OP_SLL:  result = x << shamt;
            ALU_OP_SLT:  result = {{(WORD_W-1){1'b0}}, ($signed(x) < $signed(y))};
            ALU_OP_SLTU: result = {{(WORD_W-1){1'b0}}, (x < y)};
            ALU_OP_XOR:  result = x ^ y;
            ALU_OP_SRL:  result = x >> shamt;
            ALU_OP_SRA:  result = $signed(x) >>> shamt;
            ALU_OP_OR:   result = x | y;
            ALU_OP_AND:  result = x & y;
            default:     result = '0;
        endcase
    end

endmodule

// File: rtl/alu_station.sv
// Single-entry ALU reservation station: capture, CDB snoop, execute, broadcast.
// Define ALU_CDB_BYPASS_EN to snoop the CDB during the dispatch cycle as well.
module alu_station
    import alu_station_pkg::*;
#(
    parameter int unsigned TAG_W  = TAG_BITS,
    parameter int unsigned WORD_W = WORD_BITS,
    parameter int unsigned ADDR_W = ADDR_BITS,
    parameter int unsigned MY_TAG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              en_in,
    input  logic [3:0]        op_in,
    input  logic [TAG_W-1:0]  tagx_in,
    input  logic [TAG_W-1:0]  tagy_in,
    input  logic [TAG_W-1:0]  tagw_in,
    input  logic [WORD_W-1:0] datax_in,
    input  logic [WORD_W-1:0] datay_in,
    input  logic [ADDR_W-1:0] addrw_in,
    input  logic              cdb_en,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [WORD_W-1:0] cdb_data,
    output logic              busy,
    output logic [TAG_W-1:0]  tagx_out,
    output logic [TAG_W-1:0]  tagy_out,
    output logic [TAG_W-1:0]  tagw_out,
    output logic              res_req,
    output logic [TAG_W-1:0]  res_tag,
    output logic [WORD_W-1:0] res_data,
    output logic [ADDR_W-1:0] res_addr,
    input  logic              res_ack
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_EXEC  = 2'd2;
    localparam logic [1:0] ST_BCAST = 2'd3;

    localparam logic [TAG_W-1:0] NO_TAG = TAG_W'(UNLOCKED);

    logic [1:0]        state_r;
    sinst_t            op_r;
    logic [TAG_W-1:0]  tagx_r, tagy_r, tagw_r;
    logic [WORD_W-1:0] datax_r, datay_r, res_r;
    logic [ADDR_W-1:0] addr_r;
    logic [WORD_W-1:0] core_res;

    logic hit_x, hit_y, snoop_x, snoop_y;

`ifdef ALU_CDB_BYPASS_EN
    assign hit_x = cdb_en && (tagx_in != NO_TAG) && (cdb_tag == tagx_in);
    assign hit_y = cdb_en && (tagy_in != NO_TAG) && (cdb_tag == tagy_in);
`else
    assign hit_x = 1'b0;
    assign hit_y = 1'b0;
`endif

    assign snoop_x = cdb_en && (tagx_r != NO_TAG) && (cdb_tag == tagx_r);
    assign snoop_y = cdb_en && (tagy_r != NO_TAG) && (cdb_tag == tagy_r);

    alu_core #(
        .WORD_W (WORD_W)
    ) u_core (
        .op     (op_r),
        .x      (datax_r),
        .y      (datay_r),
        .result (core_res)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            op_r    <= '0;
            tagx_r  <= '0;
            tagy_r  <= '0;
            tagw_r  <= '0;
            datax_r <= '0;
            datay_r <= '0;
            res_r   <= '0;
            addr_r  <= '0;
        end else if (rdy) begin
            case (state_r)
                ST_IDLE: begin
                    if (en_in) begin
                        op_r    <= op_in;
                        tagx_r  <= hit_x ? NO_TAG : tagx_in;
                        tagy_r  <= hit_y ? NO_TAG : tagy_in;
                        datax_r <= hit_x ? cdb_data : datax_in;
                        datay_r <= hit_y ? cdb_data : datay_in;
                        tagw_r  <= tagw_in;
                        addr_r  <= addrw_in;
                        state_r <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // Leave only once both operands were already resolved at cycle start.
                    if (tagx_r == NO_TAG && tagy_r == NO_TAG) state_r <= ST_EXEC;
                    if (snoop_x) begin
                        datax_r <= cdb_data;
                        tagx_r  <= NO_TAG;
                    end
                    if (snoop_y) begin
                        datay_r <= cdb_data;
                        tagy_r  <= NO_TAG;
                    end
                end
                ST_EXEC: begin
                    res_r   <= core_res;
                    state_r <= ST_BCAST;
                end
                ST_BCAST: begin
                    if (res_ack) begin
                        tagw_r  <= NO_TAG;
                        state_r <= ST_IDLE;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    assign busy     = (state_r != ST_IDLE);
    assign tagx_out = tagx_r;
    assign tagy_out = tagy_r;
    assign tagw_out = tagw_r;
    assign res_req  = (state_r == ST_BCAST);
    assign res_tag  = res_req ? TAG_W'(MY_TAG) : NO_TAG;
    assign res_data = res_r;
    assign res_addr = addr_r;

endmodule
